// File: rtl/fixed_point_multiply.sv
// fixed_point_multiply: iterative shift-add multiply of an 8.8 quotient by an integer, saturated result
// Ports: clk, rst (sync, active-high); in_valid/in_ready/in_q/in_b operand handshake;
//        out_valid/out_ready/out_result/out_product/out_sat result handshake.
// Build option: define FIXED_POINT_MULTIPLY_ROUND_EN for round-half-up scaling instead of truncation.
module fixed_point_multiply #(
    parameter int QW   = 16,
    parameter int FRAC = 8,
    parameter int BW   = 8,
    parameter int OW   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW-1:0]    in_q,
    input  logic [BW-1:0]    in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OW-1:0]    out_result,
    output logic [QW+BW-1:0] out_product,
    output logic             out_sat
);
    localparam int PW = QW + BW;
    localparam int CW = $clog2(BW + 1);
`ifdef FIXED_POINT_MULTIPLY_ROUND_EN
    localparam logic [PW:0] RND = (PW + 1)'(1) << (FRAC - 1);
`else
    localparam logic [PW:0] RND = '0;
`endif

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t state, state_nx;

    logic [PW-1:0] mq, acc, acc_nx;
    logic [BW-1:0] mb;
    logic [CW-1:0] cnt;
    logic [PW:0]   s;
    logic          last, sat;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;

    always_comb begin
        last   = cnt == CW'(BW - 1);
        acc_nx = mb[0] ? acc + mq : acc;
        // one spare bit so the rounding increment cannot wrap at max operands
        s      = ({1'b0, acc_nx} + RND) >> FRAC;
        sat    = |s[PW:OW];
        state_nx = state;
        if (state == IDLE && in_valid)
            state_nx = CALC;
        else if (state == CALC && last)
            state_nx = DONE;
        else if (state == DONE && out_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mq          <= '0;
            mb          <= '0;
            acc         <= '0;
            cnt         <= '0;
            out_result  <= '0;
            out_product <= '0;
            out_sat     <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && in_valid) begin
                mq  <= PW'(in_q);
                mb  <= in_b;
                acc <= '0;
                cnt <= '0;
            end else if (state == CALC) begin
                acc <= acc_nx;
                mq  <= mq << 1;
                mb  <= mb >> 1;
                cnt <= cnt + 1'b1;
                if (last) begin
                    out_product <= acc_nx;
                    out_sat     <= sat;
                    out_result  <= sat ? '1 : s[OW-1:0];
                end
            end
        end
    end
endmodule

// File: tb/tb_fixed_point_multiply.sv
// tb_fixed_point_multiply: directed self-checking bench for fixed_point_multiply
module tb_fixed_point_multiply;
    logic        clk = 0;
    logic        rst = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [15:0] in_q = 0;
    logic [7:0]  in_b = 0;
    logic        out_valid;
    logic        out_ready = 1;
    logic [7:0]  out_result;
    logic [23:0] out_product;
    logic        out_sat;
    int checks = 0;
    int failures = 0;

    fixed_point_multiply dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_q(in_q), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_product(out_product), .out_sat(out_sat)
    );

    always #5 clk = ~clk;

    // Called #1 after an edge with the DUT idle. Returns edges from accept
    // (counted as 1) to the edge raising out_valid; 99 on timeout.
    task automatic run(input logic [15:0] q, input logic [7:0] b, output int n);
        in_valid = 1; in_q = q; in_b = b;
        @(posedge clk); #1;
        in_valid = 0; in_q = 16'hA5A5; in_b = 8'h5A;
        n = 99;
        for (int i = 2; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin n = i; break; end
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_result !== 8'd0 || out_product !== 24'd0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL reset: valid=%b ready=%b res=%0d prod=%h sat=%b, want 0 1 0 0 0", out_valid, in_ready, out_result, out_product, out_sat);
        end
    endtask

    task automatic test_basic;
        int n;
        run(16'h0080, 8'd200, n);
        checks++;
        if (n !== 9) begin failures++; $display("FAIL basic_latency: got %0d want 9", n); end
        checks++;
        if (out_product !== 24'h006400 || out_result !== 8'd100 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL basic_value: prod=%h res=%0d sat=%b want 006400 100 0", out_product, out_result, out_sat);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL basic_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_rounding;
        int n;
        logic [7:0] exp_r;
`ifdef FIXED_POINT_MULTIPLY_ROUND_EN
        exp_r = 8'd14;
`else
        exp_r = 8'd13;
`endif
        run(16'h0016, 8'd160, n);
        checks++;
        if (out_product !== 24'h000DC0 || out_result !== exp_r || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL rounding: prod=%h res=%0d sat=%b want 000dc0 %0d 0", out_product, out_result, out_sat, exp_r);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_saturate;
        int n;
        run(16'hFFFF, 8'd255, n);
        checks++;
        if (out_product !== 24'hFEFF01 || out_result !== 8'd255 || out_sat !== 1'b1) begin
            failures++;
            $display("FAIL saturate: prod=%h res=%0d sat=%b want feff01 255 1", out_product, out_result, out_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero;
        int n;
        run(16'h1234, 8'd0, n);
        checks++;
        if (n !== 9) begin failures++; $display("FAIL zero_latency: got %0d want 9", n); end
        checks++;
        if (out_product !== 24'd0 || out_result !== 8'd0 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL zero_value: prod=%h res=%0d sat=%b want 0 0 0", out_product, out_result, out_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure;
        int n;
        logic [23:0] p0;
        out_ready = 0;
        in_valid = 1; in_q = 16'h0016; in_b = 8'd160;
        @(posedge clk); #1;
        in_q = 16'h0100; in_b = 8'd7;
        n = 99;
        for (int i = 2; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin n = i; break; end
        end
        checks++;
        if (n !== 9) begin failures++; $display("FAIL bp_latency: got %0d want 9", n); end
        p0 = out_product;
        checks++;
        if (p0 !== 24'h000DC0) begin failures++; $display("FAIL bp_sampled: prod=%h want 000dc0", p0); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_product !== p0) begin
                failures++;
                $display("FAIL bp_hold%0d: valid=%b ready=%b prod=%h want 1 0 %h", i, out_valid, in_ready, out_product, p0);
            end
        end
        out_ready = 1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        in_valid = 0;
        n = 99;
        for (int i = 2; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) begin n = i; break; end
        end
        checks++;
        if (n !== 9 || out_result !== 8'd7 || out_product !== 24'h000700) begin
            failures++;
            $display("FAIL bp_next: lat=%0d res=%0d prod=%h want 9 7 000700", n, out_result, out_product);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_midreset;
        int n;
        in_valid = 1; in_q = 16'h0200; in_b = 8'd50;
        @(posedge clk); #1;
        in_valid = 0;
        repeat (4) @(posedge clk);
        #1 rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: valid=%b ready=%b want 0 1", out_valid, in_ready);
        end
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) n++;
        end
        checks++;
        if (n !== 0) begin failures++; $display("FAIL midreset_discard: valid cycles=%0d want 0", n); end
        run(16'h0200, 8'd50, n);
        checks++;
        if (n !== 9 || out_result !== 8'd100 || out_sat !== 1'b0) begin
            failures++;
            $display("FAIL midreset_rerun: lat=%0d res=%0d sat=%b want 9 100 0", n, out_result, out_sat);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_rounding;
        test_saturate;
        test_zero;
        test_backpressure;
        test_midreset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
